// File: rtl/emulib_rammodel_resp_dispatch.sv
// Response dispatcher for the RAM model backend.
// Splits the 32-bit backend response stream into a B-channel stream and an
// R-channel stream. Each packet header selects the channel; R packets carry
// (len+1)*WPB payload words that follow the header on the R channel.
// Each output channel has a one-entry register stage so that a stalled
// decoder only blocks input words that target its own channel.
//
// state | meaning
// ------+-----------------------------------------------------------
// HEAD  | next accepted word is a packet header
// BODY  | forwarding R payload words, rem+1 words still to come
//
// DATA_WIDTH must be a multiple of 32 and at least 32.

module emulib_rammodel_resp_dispatch #(
    parameter int DATA_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [31:0] b_data,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [31:0] r_data,
    output logic        err,
    output logic        idle
);

    localparam int WPB   = DATA_WIDTH / 32;
    localparam int REM_W = 9 + $clog2(WPB);

    localparam logic [0:0] ST_HEAD = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    localparam logic [1:0] TYPE_B = 2'b01;
    localparam logic [1:0] TYPE_R = 2'b10;

    logic [0:0]       state;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] beats;
    logic [REM_W-1:0] rem_init;
    logic [1:0]       hdr_type;
    logic             b_free;
    logic             r_free;
    logic             accept;
    logic             b_load;
    logic             r_load;
    logic             bad_hdr;

    assign hdr_type = in_data[1:0];
    assign b_free   = !b_valid || b_ready;
    assign r_free   = !r_valid || r_ready;

    // Payload length in words minus one; 256*WPB always fits in REM_W bits.
    assign beats    = REM_W'(in_data[15:8]) + REM_W'(1);
    assign rem_init = (beats * REM_W'(WPB)) - REM_W'(1);

    // Backend flow control: only the stage the current word targets matters.
    always_comb begin
        in_ready = 1'b0;
        if (state == ST_BODY) begin
            in_ready = r_free;
        end else begin
            case (hdr_type)
                TYPE_B:  in_ready = b_free;
                TYPE_R:  in_ready = r_free;
                default: in_ready = 1'b1;
            endcase
        end
    end

    assign accept  = in_valid && in_ready;
    assign b_load  = accept && (state == ST_HEAD) && (hdr_type == TYPE_B);
    assign r_load  = accept && ((state == ST_BODY) || (hdr_type == TYPE_R));
    assign bad_hdr = accept && (state == ST_HEAD) &&
                     (hdr_type != TYPE_B) && (hdr_type != TYPE_R);

    // Packet framing: header parsing and payload word countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HEAD;
            rem   <= '0;
        end else if (accept) begin
            if (state == ST_HEAD) begin
                if (hdr_type == TYPE_R) begin
                    state <= ST_BODY;
                    rem   <= rem_init;
                end
            end else if (rem == '0) begin
                state <= ST_HEAD;
            end else begin
                rem <= rem - REM_W'(1);
            end
        end
    end

    // Sticky flag for headers with an unknown type; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bad_hdr) begin
            err <= 1'b1;
        end
    end

    // B stage occupancy: a load wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
        end else if (b_load) begin
            b_valid <= 1'b1;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

    // B stage payload; contents are meaningless while b_valid is low.
    always_ff @(posedge clk) begin
        if (b_load) begin
            b_data <= in_data;
        end
    end

    // R stage occupancy: a load wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (r_load) begin
            r_valid <= 1'b1;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

    // R stage payload; contents are meaningless while r_valid is low.
    always_ff @(posedge clk) begin
        if (r_load) begin
            r_data <= in_data;
        end
    end

    assign idle = (state == ST_HEAD) && !b_valid && !r_valid;

endmodule
